// File: rtl/sopc_scope_sys_nios2_qsys_0_mul_pkg.sv
// Shared types and constants for the sequential 32x32 multiplier.
// Holds op codes, sequencer states, the product tag and partial-product alignment.
package sopc_scope_sys_nios2_qsys_0_mul_pkg;

  localparam int HALF_W = 16;
  localparam int WORD_W = 32;
  localparam int ACC_W  = 64;

  typedef enum logic [1:0] {
    MUL_LO = 2'd0,
    MULXUU = 2'd1,
    MULXSU = 2'd2,
    MULXSS = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    DRAIN = 3'd2,
    FIX   = 3'd3,
    DONE  = 3'd4
  } state_e;

  // Travels alongside the multiplier pipeline so each product knows its weight.
  typedef struct packed {
    logic       vld;
    logic [1:0] idx;
  } pp_tag_t;

  // idx bit0 selects A's high half, bit1 selects B's high half.
  function automatic logic [ACC_W-1:0] pp_align(input logic [2*HALF_W-1:0] p,
                                                 input logic [1:0]          idx);
    logic [ACC_W-1:0] ext;
    ext = {{(ACC_W-2*HALF_W){1'b0}}, p};
    case (idx)
      2'd0:    pp_align = ext;
      2'd3:    pp_align = ext << (2*HALF_W);
      default: pp_align = ext << HALF_W;
    endcase
  endfunction

endpackage

// File: rtl/sopc_scope_sys_nios2_qsys_0_mul16_reg.sv
// 16x16 unsigned multiplier with MULT_REG output register stages.
// Pipeline stages clear on synchronous reset.
module sopc_scope_sys_nios2_qsys_0_mul16_reg
  import sopc_scope_sys_nios2_qsys_0_mul_pkg::*;
#(
  parameter int MULT_REG = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [HALF_W-1:0]   a,
  input  logic [HALF_W-1:0]   b,
  output logic [2*HALF_W-1:0] p
);

  logic [2*HALF_W-1:0] prod;
  assign prod = {{HALF_W{1'b0}}, a} * {{HALF_W{1'b0}}, b};

  generate
    if (MULT_REG == 0) begin : g_comb
      assign p = prod;
    end else begin : g_reg
      logic [2*HALF_W-1:0] stage [MULT_REG];

      // NOTE: sequential state uses non-blocking (<=) so every stage samples
      // the pre-edge value of its predecessor; blocking would collapse the pipe.
      always_ff @(posedge clk) begin
        if (reset) begin
          for (int i = 0; i < MULT_REG; i++) stage[i] <= '0;
        end else begin
          stage[0] <= prod;
          for (int i = 1; i < MULT_REG; i++) stage[i] <= stage[i-1];
        end
      end

      assign p = stage[MULT_REG-1];
    end
  endgenerate

endmodule

// File: rtl/sopc_scope_sys_nios2_qsys_0_mul_seq.sv
// Multi-cycle 32x32 multiply sequencer: four 16x16 partial products are
// accumulated into 64 bits, sign-corrected, and the low or high word returned.
module sopc_scope_sys_nios2_qsys_0_mul_seq
  import sopc_scope_sys_nios2_qsys_0_mul_pkg::*;
#(
  parameter int MULT_REG = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_op,
  input  logic [WORD_W-1:0] in_src1,
  input  logic [WORD_W-1:0] in_src2,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_result,
  output logic              busy
);

  localparam logic [1:0] DRAIN_LAST = (MULT_REG > 0) ? 2'(MULT_REG - 1) : 2'd0;

  state_e              state_q, state_d;
  logic [1:0]          cnt_q, cnt_d;
  op_e                 op_q;
  logic [WORD_W-1:0]   a_q, b_q;
  logic [ACC_W-1:0]    acc_q;
  logic [WORD_W-1:0]   result_q;
  logic                accept, load_result;

  logic [HALF_W-1:0]   half_a, half_b;
  logic [2*HALF_W-1:0] mul_p;
  pp_tag_t             tag_in, tag_out;

  logic [WORD_W-1:0]   hi_raw, corr_b, corr_a, hi_fix;

  // NOTE: every signal driven in always_comb gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    accept      = 1'b0;
    load_result = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          accept  = 1'b1;
          state_d = ISSUE;
          cnt_d   = 2'd0;
        end
      end
      ISSUE: begin
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          cnt_d   = 2'd0;
          state_d = (MULT_REG == 0) ? FIX : DRAIN;
        end
      end
      DRAIN: begin
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == DRAIN_LAST) begin
          cnt_d   = 2'd0;
          state_d = FIX;
        end
      end
      FIX: begin
        load_result = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready   = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign out_valid  = (state_q == DONE);
  assign out_result = result_q;

  assign half_a     = cnt_q[0] ? a_q[WORD_W-1:HALF_W] : a_q[HALF_W-1:0];
  assign half_b     = cnt_q[1] ? b_q[WORD_W-1:HALF_W] : b_q[HALF_W-1:0];
  assign tag_in.vld = (state_q == ISSUE);
  assign tag_in.idx = cnt_q;

  sopc_scope_sys_nios2_qsys_0_mul16_reg #(.MULT_REG(MULT_REG)) u_mul16 (
    .clk   (clk),
    .reset (reset),
    .a     (half_a),
    .b     (half_b),
    .p     (mul_p)
  );

  generate
    if (MULT_REG == 0) begin : g_tag_comb
      assign tag_out = tag_in;
    end else begin : g_tag_reg
      pp_tag_t tag_pipe [MULT_REG];

      // NOTE: this small register array is cleared on reset because a stale
      // valid tag would add a phantom product after an aborted operation.
      always_ff @(posedge clk) begin
        if (reset) begin
          for (int i = 0; i < MULT_REG; i++) tag_pipe[i] <= '0;
        end else begin
          tag_pipe[0] <= tag_in;
          for (int i = 1; i < MULT_REG; i++) tag_pipe[i] <= tag_pipe[i-1];
        end
      end

      assign tag_out = tag_pipe[MULT_REG-1];
    end
  endgenerate

  // Unsigned high word minus the two's-complement sign terms, mod 2^32.
  assign hi_raw = acc_q[ACC_W-1:WORD_W];
  assign corr_b = ((op_q == MULXSU || op_q == MULXSS) && a_q[WORD_W-1]) ? b_q : '0;
  assign corr_a = ((op_q == MULXSS) && b_q[WORD_W-1]) ? a_q : '0;
  assign hi_fix = hi_raw - corr_b - corr_a;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= 2'd0;
      op_q     <= MUL_LO;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        op_q  <= op_e'(in_op);
        a_q   <= in_src1;
        b_q   <= in_src2;
        acc_q <= '0;
      end else if (tag_out.vld) begin
        acc_q <= acc_q + pp_align(mul_p, tag_out.idx);
      end
      if (load_result) begin
        result_q <= (op_q == MUL_LO) ? acc_q[WORD_W-1:0] : hi_fix;
      end
    end
  end

endmodule
